// File: rtl/bypass_fifo_storage.sv
// WIDTH x DEPTH register array for bypass_fifo: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the control logic never exposes an unwritten slot.
module bypass_fifo_storage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic             clock,
    input  logic             write_enable,
    input  logic [PW-1:0]    write_address,
    input  logic [WIDTH-1:0] write_data,
    input  logic [PW-1:0]    read_address,
    output logic [WIDTH-1:0] read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    assign read_data = mem[read_address];

endmodule

// File: rtl/bypass_fifo.sv
// DEPTH-entry FIFO with a zero-latency write->read bypass when empty.
// Define BYPASS_FIFO_PROTECTION_EN to drop illegal requests and raise a sticky error flag.
module bypass_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       write_enable,
    input  logic [WIDTH-1:0]           write_data,
    output logic                       full,
    input  logic                       read_enable,
    output logic [WIDTH-1:0]           read_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       error
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    // Handshake: a beat transfers on a rising edge when its enable is high; the
    // caller may raise write_enable only while full is low and read_enable only
    // while empty is low, one cycle per beat. full/empty see the opposite enable.
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic [WIDTH-1:0] head_data;
    logic             is_empty;
    logic             is_full;
    logic             bypass;
    logic             do_write;
    logic             do_read;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign is_empty = (count == '0);
    assign is_full  = (count == LW'(DEPTH));
    assign bypass   = is_empty && write_enable && read_enable;

`ifdef BYPASS_FIFO_PROTECTION_EN
    logic illegal;
    assign illegal  = (write_enable && is_full && !read_enable) ||
                      (read_enable && is_empty && !write_enable);
    assign do_write = write_enable && !bypass && (!is_full || read_enable);
    assign do_read  = read_enable && !is_empty;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            error <= 1'b0;
        end else if (illegal) begin
            error <= 1'b1;
        end
    end
`else
    assign do_write = write_enable && !bypass;
    assign do_read  = read_enable && !bypass;
    assign error    = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_read) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_write && !do_read) begin
                count <= count + LW'(1);
            end else if (do_read && !do_write) begin
                count <= count - LW'(1);
            end
        end
    end

    // At full with a same-cycle read, wr_ptr == rd_ptr: the async read still
    // returns the old head while the new word lands on the edge.
    bypass_fifo_storage #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .PW   (PW)
    ) u_storage (
        .clock        (clock),
        .write_enable (do_write),
        .write_address(wr_ptr),
        .write_data   (write_data),
        .read_address (rd_ptr),
        .read_data    (head_data)
    );

    assign empty     = is_empty && !write_enable;
    assign full      = is_full && !read_enable;
    assign read_data = is_empty ? write_data : head_data;
    assign level     = count;

endmodule

// File: doc/bypass_fifo.md
# bypass_fifo

Parametrised-depth successor to the single-entry bypass buffer: a DEPTH-entry synchronous FIFO with read/write-enable handshakes. A write into an empty FIFO with a same-cycle read passes straight to `read_data` combinationally, with zero latency and no storage. A read from a full FIFO frees a slot for a same-cycle write. The block sits between a producer and consumer that poll `full`/`empty` and assert enables for one cycle per beat.

## Interface
- `WIDTH`, default 8: data width in bits, ≥1.
- `DEPTH`, default 4: storage entries, ≥1; need not be a power of two.
- `clock`, input, 1: sole clock, rising edge.
- `resetn`, input, 1: asynchronous active-low reset.
- `write_enable`, input, 1: push `write_data` this cycle.
- `write_data`, input, WIDTH: data to push.
- `full`, output, 1: no write may be accepted this cycle.
- `read_enable`, input, 1: pop `read_data` this cycle.
- `read_data`, output, WIDTH: head data, or `write_data` in bypass.
- `empty`, output, 1: no read may be accepted this cycle.
- `level`, output, $clog2(DEPTH+1): stored entry count, registered.
- `error`, output, 1: sticky protocol-violation flag (see Configuration).

## Operation
- State: storage array of DEPTH entries, write pointer and read pointer (0..DEPTH-1, wrap DEPTH-1→0), and a count 0..DEPTH (`level`).
- `empty = (count==0) && !write_enable`.
- `full = (count==DEPTH) && !read_enable`.
- `read_data` selection:
  - If count==0: `read_data = write_data`.
  - Otherwise: `read_data` is the entry at the read pointer.
- Bypass: count==0 with write and read asserted. Nothing is stored; pointers and count are unchanged.
- Write only, count<DEPTH: store at the write pointer, advance it, count+1.
- Read only, count>0: advance the read pointer, count−1.
- Write and read, 0<count<DEPTH: store and advance both pointers; count unchanged.
- Write and read at count==DEPTH: legal. The head is popped and the new word is stored in the freed slot; count stays DEPTH.
- Illegal requests, handled per Configuration:
  - write when count==DEPTH and no read;
  - read when count==0 and no write.
- FIFO order is strict. Data leaves in the order accepted, including across bypass cycles.

## Timing
- Reset, asynchronous on `resetn` low: pointers 0, count 0, `error` 0.
  - While `resetn` is low: `level`=0; `full`=0; `empty` = `!write_enable`; `read_data` = `write_data`.
  - Storage contents are not reset.
- Reset mid-operation discards all stored entries immediately.
- Latency:
  - Bypass: 0 cycles, combinational `write_data`→`read_data`.
  - Stored word: readable the cycle after it is written.
- Combinational paths: `write_enable`→`empty` and `read_enable`→`full`. Callers must not close a loop through them, for example by driving `write_enable` from `full`.
- `level` updates on the clock edge after the accepted transfer.
- DEPTH=1 behaves cycle-identically to the single-entry bypass buffer.

## Configuration
- Macro: `BYPASS_FIFO_PROTECTION_EN`.
- Defined:
  - Illegal writes are dropped and illegal reads do not move the pointers.
  - Either violation sets `error` on the next edge; `error` stays set until reset.
- Undefined:
  - No protection logic; `error` is tied to 0.
  - Illegal requests give undefined contents. Pointers still wrap modulo DEPTH, never out of range.

## Structure
- No shared package is needed.
- Pointer width `$clog2(DEPTH)` (min 1) and level width `$clog2(DEPTH+1)` are local parameters.
- One sub-module, `bypass_fifo_storage`: a WIDTH×DEPTH register array.
  - Write port: synchronous, `write_enable`, `write_address`, `write_data`.
  - Read port: asynchronous, `read_address`→`read_data`.
- Pointer/count control and the bypass mux live in the top module.

## Test plan
- Reset then idle: `empty`=1, `full`=0, `level`=0, `error`=0. Drive `write_data`=AA with both enables: `read_data`=AA, `empty`=0, `full`=0; next cycle `level`=0.
- Fill, DEPTH=4: write 00..03 on 4 cycles → `full`=1, `level`=4. Read 4 cycles → 00,01,02,03 in order, then `empty`=1.
- Full with simultaneous read and write 04 → `full`=0 that cycle, `read_data`=00, `level` stays 4. Draining gives 01,02,03,04.
- Continuous bypass: 100 cycles of both enables with incrementing data, count 0 → `read_data`==`write_data` every cycle, `level` stays 0.
- Protection on: write 05 when full without a read → dropped, `error`=1 next edge, contents unchanged. Then assert `resetn`=0 mid-stream → `level`=0, `error`=0, `empty`=1.
- Random: 1000 cycles, write/read probability 0.5 each, enables gated by `full`/`empty`, scoreboard queue → zero mismatches, and the FIFO is empty after draining. Run with DEPTH 1, 3 and 4.
